// File: rtl/vga_pkg.sv
// Shared timing constants and coordinate helpers for the 640x480 @ 60 Hz raster.
package vga_pkg;
  localparam int COORD_W = 11;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_FP        = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_V_FP        = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 33;
  localparam int DEF_MUX_LATENCY = 1;

  localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  // {hSyncN, vSyncN, blankN} when nothing is being displayed
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  function automatic logic in_window(input logic [COORD_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction
endpackage

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH shift register; reset loads RST_VAL into every stage.
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters, coordinate stage and DAC output stage with
// sync/blank delayed to line up with the object mux's registered colour.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int MUX_LATENCY = DEF_MUX_LATENCY
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic [7:0]   redIn,
  input  logic [7:0]   greenIn,
  input  logic [7:0]   blueIn,
  output logic [10:0]  pixelX,
  output logic [10:0]  pixelY,
  output logic         pixelValid,
  output logic         startOfFrame,
  output logic [7:0]   frameCount,
  output logic [7:0]   vgaR,
  output logic [7:0]   vgaG,
  output logic [7:0]   vgaB,
  output logic         hSyncN,
  output logic         vSyncN,
  output logic         blankN
);
  localparam int H_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int D     = MUX_LATENCY + 1;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_LEN - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_LEN - 1);
  localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_ACTIVE);

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [COORD_W-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic               sof_q, sof_d;
  logic [23:0]        rgb_q, rgb_d;
  logic [2:0]         sync_raw, sync_dly;

  always_comb begin
    h_cnt_d     = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (h_cnt_q == H_LAST) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      if (v_cnt_q == V_LAST) frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Coordinate stage: one register behind the counters so pixel 0,0 is the
  // first thing seen after reset release.
  always_comb begin
    pixel_x_d     = h_cnt_q;
    pixel_y_d     = v_cnt_q;
    pixel_valid_d = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    sof_d         = (h_cnt_q == '0) && (v_cnt_q == '0);
    rgb_d         = {redIn, greenIn, blueIn};
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_cnt_q   <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_valid_q <= 1'b0;
      sof_q         <= 1'b0;
      rgb_q         <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pixel_valid_q <= pixel_valid_d;
      sof_q         <= sof_d;
      rgb_q         <= rgb_d;
    end
  end

  assign sync_raw = {~in_window(pixel_x_q, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC),
                     ~in_window(pixel_y_q, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC),
                     pixel_valid_q};

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (D),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk    (clk),
    .resetN (resetN),
    .din    (sync_raw),
    .dout   (sync_dly)
  );

  assign hSyncN       = sync_dly[2];
  assign vSyncN       = sync_dly[1];
  assign blankN       = sync_dly[0];
  assign {vgaR, vgaG, vgaB} = sync_dly[0] ? rgb_q : 24'd0;

  assign pixelX       = pixel_x_q;
  assign pixelY       = pixel_y_q;
  assign pixelValid   = pixel_valid_q;
  assign startOfFrame = sof_q;
  assign frameCount   = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance for line-level behaviour and a
// shrunken-raster instance for frame-level behaviour and mid-frame reset.
module tb_vga_timing_gen;
  logic        clk = 1'b0;
  logic        resetN, s_resetN;
  logic [7:0]  red, green, blue, s_red, s_green, s_blue;

  logic [10:0] px, py, s_px, s_py;
  logic        pv, sof, hs, vs, bn, s_pv, s_sof, s_hs, s_vs, s_bn;
  logic [7:0]  fc, vr, vg, vb, s_fc, s_vr, s_vg, s_vb;

  int n_cmp = 0;
  int n_err = 0;
  int hs_first = -1;
  int hs_cnt = 0;
  int s_vs_low = 0;
  int sof_prev = -1;
  int sof_gap = -1;

  always #20 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .resetN(resetN), .redIn(red), .greenIn(green), .blueIn(blue),
    .pixelX(px), .pixelY(py), .pixelValid(pv), .startOfFrame(sof), .frameCount(fc),
    .vgaR(vr), .vgaG(vg), .vgaB(vb), .hSyncN(hs), .vSyncN(vs), .blankN(bn)
  );

  // 24 x 14 raster: hsync cols 18..21, vsync lines 10..11, 336 clocks per frame
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .MUX_LATENCY(1)
  ) u_small (
    .clk(clk), .resetN(s_resetN), .redIn(s_red), .greenIn(s_green), .blueIn(s_blue),
    .pixelX(s_px), .pixelY(s_py), .pixelValid(s_pv), .startOfFrame(s_sof), .frameCount(s_fc),
    .vgaR(s_vr), .vgaG(s_vg), .vgaB(s_vb), .hSyncN(s_hs), .vSyncN(s_vs), .blankN(s_bn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {hSyncN, vSyncN, blankN} in pixel cycle c (2-clock output delay)
  function automatic logic [2:0] exp_sync(input int c, input int ht, input int vt, input int ha,
                                          input int va, input int hs0, input int hs1,
                                          input int vs0, input int vs1);
    int p, x, y;
    if (c < 2) return 3'b110;
    p = c - 2;
    x = p % ht;
    y = (p / ht) % vt;
    return {!(x >= hs0 && x < hs1), !(y >= vs0 && y < vs1), (x < ha && y < va)};
  endfunction

  task automatic chk_main(input int c);
    int x, y, p;
    logic [2:0] e;
    logic [7:0] er;
    x = c % 800;
    y = (c / 800) % 525;
    p = c - 2;
    e = exp_sync(c, 800, 525, 640, 480, 656, 752, 490, 492);
    chk("m_pixelX", 32'(px), x);
    chk("m_pixelY", 32'(py), y);
    chk("m_pixelValid", 32'(pv), 32'(x < 640 && y < 480));
    chk("m_sof", 32'(sof), 32'(c == 0));
    chk("m_hSyncN", 32'(hs), 32'(e[2]));
    chk("m_vSyncN", 32'(vs), 32'(e[1]));
    chk("m_blankN", 32'(bn), 32'(e[0]));
    er = 8'h00;
    if (c >= 2 && e[0]) er = (p < 800) ? 8'(p % 256) : 8'hFF;
    chk("m_vgaR", 32'(vr), 32'(er));
    chk("m_vgaG", 32'(vg), 32'h0);
    chk("m_vgaB", 32'(vb), 32'h0);
  endtask

  task automatic chk_small(input int c);
    int x, y;
    logic [2:0] e;
    x = c % 24;
    y = (c / 24) % 14;
    e = exp_sync(c, 24, 14, 16, 8, 18, 22, 10, 12);
    chk("s_pixelX", 32'(s_px), x);
    chk("s_pixelY", 32'(s_py), y);
    chk("s_pixelValid", 32'(s_pv), 32'(x < 16 && y < 8));
    chk("s_sof", 32'(s_sof), 32'(c % 336 == 0));
    if (c % 336 == 0) chk("s_frameCount", 32'(s_fc), (c / 336) % 256);
    chk("s_hSyncN", 32'(s_hs), 32'(e[2]));
    chk("s_vSyncN", 32'(s_vs), 32'(e[1]));
    chk("s_blankN", 32'(s_bn), 32'(e[0]));
    chk("s_vgaR", 32'(s_vr), (c >= 2 && e[0]) ? 32'h5A : 32'h0);
  endtask

  initial begin
    resetN = 1'b0; s_resetN = 1'b0;
    red = 8'hFF; green = 8'h00; blue = 8'h00;
    s_red = 8'h5A; s_green = 8'h00; s_blue = 8'h00;

    repeat (5) begin
      @(negedge clk);
      chk("rst_hSyncN", 32'(hs), 32'h1);
      chk("rst_vSyncN", 32'(vs), 32'h1);
      chk("rst_blankN", 32'(bn), 32'h0);
      chk("rst_vgaR", 32'(vr), 32'h0);
      chk("rst_pixelX", 32'(px), 32'h0);
      chk("rst_pixelY", 32'(py), 32'h0);
      chk("rst_pixelValid", 32'(pv), 32'h0);
      chk("rst_sof", 32'(sof), 32'h0);
      chk("rst_frameCount", 32'(fc), 32'h0);
      chk("rst_s_hSyncN", 32'(s_hs), 32'h1);
      chk("rst_s_blankN", 32'(s_bn), 32'h0);
    end
    resetN = 1'b1; s_resetN = 1'b1;

    // Line 0 colour comes from a 1-cycle mux returning pixelX[7:0]; later lines are red FF
    for (int c = 0; c <= 1629; c++) begin
      @(negedge clk);
      chk_main(c);
      chk_small(c);
      if (c >= 2 && c <= 801 && hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
      end
      if (c >= 2 && c <= 337 && s_vs === 1'b0) s_vs_low++;
      if (s_sof === 1'b1) begin
        if (sof_prev >= 0 && sof_gap < 0) sof_gap = c - sof_prev;
        sof_prev = c;
      end
      red = (c >= 1 && c <= 800) ? 8'((c - 1) % 256) : 8'hFF;
    end
    chk("hsync_first_low", hs_first, 658);
    chk("hsync_low_len", hs_cnt, 96);
    chk("s_vsync_low_len", s_vs_low, 48);
    chk("s_sof_spacing", sof_gap, 336);

    // Small raster now shows pixel (19,11): inside both sync pulses
    chk("pre_s_hSyncN", 32'(s_hs), 32'h0);
    chk("pre_s_vSyncN", 32'(s_vs), 32'h0);
    s_resetN = 1'b0;
    @(negedge clk);
    chk("mid_s_hSyncN", 32'(s_hs), 32'h1);
    chk("mid_s_vSyncN", 32'(s_vs), 32'h1);
    chk("mid_s_blankN", 32'(s_bn), 32'h0);
    chk("mid_s_pixelX", 32'(s_px), 32'h0);
    chk("mid_s_pixelY", 32'(s_py), 32'h0);
    chk("mid_s_frameCount", 32'(s_fc), 32'h0);
    s_resetN = 1'b1;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      chk_small(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator and pixel output stage for the 640x480 @ 60 Hz VGA display. It produces the pixel coordinates that all object drawers consume and takes back the 24-bit colour from the object priority mux. It drives the DAC colour, sync and blank outputs, delaying sync and blank so they stay aligned with the mux's registered colour.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- MUX_LATENCY, 1, register stages between pixelX/pixelY and redIn/greenIn/blueIn

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  pixel clock, 25.175 MHz nominal
- resetN  in  1  synchronous active-low reset
- redIn  in  8  red from object mux
- greenIn  in  8  green from object mux
- blueIn  in  8  blue from object mux
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1
- pixelY  out  11  current vertical count, 0..V_TOTAL-1
- pixelValid  out  1  high when pixelX < H_ACTIVE and pixelY < V_ACTIVE
- startOfFrame  out  1  one-cycle pulse when pixelX==0 and pixelY==0
- frameCount  out  8  frame counter, wraps 255->0
- vgaR  out  8  red to DAC
- vgaG  out  8  green to DAC
- vgaB  out  8  blue to DAC
- hSyncN  out  1  horizontal sync, active low
- vSyncN  out  1  vertical sync, active low
- blankN  out  1  low outside the visible area

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- hCnt increments every clock and wraps H_TOTAL-1 -> 0. On that wrap, vCnt increments and wraps V_TOTAL-1 -> 0.
- frameCount increments on the clock where hCnt and vCnt both wrap to 0.
- pixelX = hCnt and pixelY = vCnt, both registered. pixelValid and startOfFrame are registered and aligned with pixelX/pixelY.
- Raw sync decode from the coordinate stage:
  - hSync is active when H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vSync is active when V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blank is active when pixelValid is low.
- Raw hSync, vSync and blank pass through a delay line of D = MUX_LATENCY+1 stages.
- redIn, greenIn and blueIn are registered once, then forced to 0 when the delayed blank is active.
- Counter state has no mode or FSM. The raster is free-running and has no enable.

## Timing
- Reset values (resetN low at a clk edge):
  - hCnt=vCnt=0, frameCount=0
  - pixelValid=0, startOfFrame=0
  - vgaR/G/B=0
  - hSyncN=1, vSyncN=1, blankN=0
  - all delay-line stages load the inactive values
- First cycle after reset release: pixelX=0, pixelY=0, pixelValid=1, startOfFrame=1.
- Alignment: coordinates for pixel P appear in cycle t. The mux presents P's colour in cycle t+MUX_LATENCY. vgaR/G/B, hSyncN, vSyncN and blankN for P all appear in cycle t+D (t+2 by default).
- hSyncN is low for exactly 96 clocks per line. vSyncN is low for exactly 2x800 clocks per frame.
- The vSyncN edges coincide with the hSyncN-stage clock at hCnt==0 of lines 490 and 492.
- Reset asserted mid-frame: counters return to 0 on the same edge. The delay line is flushed to inactive, so no partial sync pulse is emitted after release.
- startOfFrame occurs exactly once per V_TOTAL*H_TOTAL = 420000 clocks.

## Structure
- Package vga_pkg holds:
  - the default timing constants
  - H_TOTAL and V_TOTAL localparams
  - the coordinate width (11)
  - the sync-region bounds
- Sub-module sync_delay_line: a parameterized WIDTH x DEPTH shift register with a synchronous reset value. It is instantiated once with WIDTH=3 and DEPTH=D.

## Test plan
- Reset held 5 clocks, then released -> during reset, hSyncN=1, vSyncN=1, blankN=0, RGB=0. After release: pixelX=0, pixelY=0, startOfFrame=1, then pixelX=1 on the next clock.
- Run one full line -> pixelX wraps 799->0 with pixelY 0->1. hSyncN goes low at output cycle 656+2 and stays low for 96 clocks.
- Constant redIn=8'hFF and green/blue=8'h00 -> vgaR=FF exactly while blankN=1, and 0 in the porch and sync regions. The first FF appears 2 clocks after pixelX=0.
- Mux model returning redIn=pixelX[7:0] with 1-cycle latency -> vgaR equals the low byte of the column index for every visible pixel of line 0.
- Run 2 full frames -> startOfFrame pulses 420000 clocks apart, frameCount 0->1->2. vSyncN is low for 1600 clocks starting at line 490.
- Assert resetN mid-frame at pixelX=700, pixelY=491 (during vsync) -> the next clock shows vSyncN=1 and hSyncN=1. Counters restart at 0,0 with no spurious sync pulse.
